// File: rtl/rggen_register_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
//   Shared types for the register access arbiter and related register-file
//   infrastructure.
//   - rggen_status          : access response status (OKAY, EXOKAY,
//                             SLAVE_ERROR, DECODE_ERROR)
//   - rggen_arbiter_state   : arbiter FSM state (IDLE, BUSY, RESPOND)
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_ARBITER_IDLE    = 2'b00,
        RGGEN_ARBITER_BUSY    = 2'b01,
        RGGEN_ARBITER_RESPOND = 2'b10
    } rggen_arbiter_state;

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_round_robin_arbiter
//   Purely combinational round-robin selector. The winner is the first set
//   request at or after the pointer, searching upward with modulo-N wrap.
//   Ports:
//     i_request      [N]          request vector
//     i_pointer      [clog2(N)]   highest-priority index (must be < N)
//     o_grant        [N]          one-hot grant, zero when no request
//     o_next_pointer [clog2(N)]   winner+1 mod N, or i_pointer when idle
// ---------------------------------------------------------------------------
module rggen_round_robin_arbiter #(
    parameter int N = 2,
    localparam int PTR_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         i_request,
    input  logic [PTR_WIDTH-1:0] i_pointer,
    output logic [N-1:0]         o_grant,
    output logic [PTR_WIDTH-1:0] o_next_pointer
);

    // One spare bit so pointer+offset (at most 2N-2) never overflows.
    localparam logic [PTR_WIDTH:0] N_LIMIT = (PTR_WIDTH + 1)'(N);

    logic [PTR_WIDTH:0] w_index;
    logic [PTR_WIDTH:0] w_next;
    logic               w_found;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_grant        = '0;
        o_next_pointer = i_pointer;
        w_found        = 1'b0;
        w_index        = '0;
        w_next         = '0;
        for (int offset = 0; offset < N; offset++) begin
            w_index = {1'b0, i_pointer} + (PTR_WIDTH + 1)'(offset);
            if (w_index >= N_LIMIT) begin
                w_index = w_index - N_LIMIT;
            end
            if (!w_found && i_request[w_index[PTR_WIDTH-1:0]]) begin
                w_found                            = 1'b1;
                o_grant[w_index[PTR_WIDTH-1:0]]    = 1'b1;
                w_next                             = w_index + (PTR_WIDTH + 1)'(1);
                if (w_next >= N_LIMIT) begin
                    w_next = '0;
                end
                o_next_pointer = w_next[PTR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/rggen_register_access_arbiter.sv
// ---------------------------------------------------------------------------
// rggen_register_access_arbiter
//   Shares one register-file access channel between N_REQUESTERS hosts.
//   Requesters are granted round-robin; one access is forwarded at a time and
//   the grant is held until i_ack, then a one-cycle response pulse goes back
//   to the granted requester only.
//
//   Optional feature macro: RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
//     When defined, an access still unacknowledged in its TIMEOUT_CYCLES-th
//     BUSY cycle is abandoned with RGGEN_SLAVE_ERROR and zero read data.
//     When undefined, BUSY waits indefinitely for i_ack.
//
//   Ports:
//     i_clk, i_rst_n         clock, asynchronous active-low reset
//     i_req_valid/o_req_ready per-requester handshake (ready is one-hot)
//     i_req_write/address/write_data/strobe  per-requester access fields
//     o_rsp_valid            per-requester one-cycle response pulse
//     o_rsp_status/read_data common registered response (held until next)
//     o_valid/o_write/o_address/o_write_data/o_strobe  downstream access
//     i_ack/i_status/i_read_data  downstream completion, sampled in BUSY
// ---------------------------------------------------------------------------
module rggen_register_access_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int N_REQUESTERS   = 2,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic [N_REQUESTERS-1:0]                     i_req_valid,
    output logic [N_REQUESTERS-1:0]                     o_req_ready,
    input  logic [N_REQUESTERS-1:0]                     i_req_write,
    input  logic [N_REQUESTERS-1:0][ADDRESS_WIDTH-1:0]  i_req_address,
    input  logic [N_REQUESTERS-1:0][BUS_WIDTH-1:0]      i_req_write_data,
    input  logic [N_REQUESTERS-1:0][BUS_WIDTH-1:0]      i_req_strobe,
    output logic [N_REQUESTERS-1:0]                     o_rsp_valid,
    output rggen_status                                 o_rsp_status,
    output logic [BUS_WIDTH-1:0]                        o_rsp_read_data,
    output logic                                        o_valid,
    output logic                                        o_write,
    output logic [ADDRESS_WIDTH-1:0]                    o_address,
    output logic [BUS_WIDTH-1:0]                        o_write_data,
    output logic [BUS_WIDTH-1:0]                        o_strobe,
    input  logic                                        i_ack,
    input  rggen_status                                 i_status,
    input  logic [BUS_WIDTH-1:0]                        i_read_data
);

    localparam int PTR_WIDTH = $clog2(N_REQUESTERS);

    rggen_arbiter_state             r_state;
    rggen_arbiter_state             w_state_next;
    logic [PTR_WIDTH-1:0]           r_pointer;
    logic [N_REQUESTERS-1:0]        r_grant;
    logic                           r_write;
    logic [ADDRESS_WIDTH-1:0]       r_address;
    logic [BUS_WIDTH-1:0]           r_write_data;
    logic [BUS_WIDTH-1:0]           r_strobe;
    rggen_status                    r_rsp_status;
    logic [BUS_WIDTH-1:0]           r_rsp_read_data;

    logic [N_REQUESTERS-1:0]        w_grant;
    logic [PTR_WIDTH-1:0]           w_next_pointer;
    logic                           w_sel_write;
    logic [ADDRESS_WIDTH-1:0]       w_sel_address;
    logic [BUS_WIDTH-1:0]           w_sel_write_data;
    logic [BUS_WIDTH-1:0]           w_sel_strobe;
    logic                           w_accept;
    logic                           w_ack;
    logic                           w_expired;

    rggen_round_robin_arbiter #(
        .N (N_REQUESTERS)
    ) u_round_robin (
        .i_request      (i_req_valid),
        .i_pointer      (r_pointer),
        .o_grant        (w_grant),
        .o_next_pointer (w_next_pointer)
    );

    // AND-OR mux of the winner's fields; the grant is one-hot or zero.
    always_comb begin
        w_sel_write      = 1'b0;
        w_sel_address    = '0;
        w_sel_write_data = '0;
        w_sel_strobe     = '0;
        for (int i = 0; i < N_REQUESTERS; i++) begin
            if (w_grant[i]) begin
                w_sel_write      = w_sel_write      | i_req_write[i];
                w_sel_address    = w_sel_address    | i_req_address[i];
                w_sel_write_data = w_sel_write_data | i_req_write_data[i];
                w_sel_strobe     = w_sel_strobe     | i_req_strobe[i];
            end
        end
    end

    assign w_accept = (r_state == RGGEN_ARBITER_IDLE) && (|i_req_valid);
    assign w_ack    = (r_state == RGGEN_ARBITER_BUSY) && i_ack;

`ifdef RGGEN_REGISTER_ACCESS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_timeout_count;

    // Held at zero outside BUSY, so it reads zero in the first BUSY cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout_count <= '0;
        end else if (r_state != RGGEN_ARBITER_BUSY) begin
            r_timeout_count <= '0;
        end else begin
            r_timeout_count <= r_timeout_count + 16'd1;
        end
    end

    assign w_expired = (r_state == RGGEN_ARBITER_BUSY) && (r_timeout_count == TIMEOUT_LAST);
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RGGEN_ARBITER_IDLE: begin
                if (w_accept) begin
                    w_state_next = RGGEN_ARBITER_BUSY;
                end
            end
            RGGEN_ARBITER_BUSY: begin
                if (i_ack || w_expired) begin
                    w_state_next = RGGEN_ARBITER_RESPOND;
                end
            end
            RGGEN_ARBITER_RESPOND: begin
                w_state_next = RGGEN_ARBITER_IDLE;
            end
            default: begin
                w_state_next = RGGEN_ARBITER_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RGGEN_ARBITER_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every datapath register is reset, so an access aborted by reset
    // leaves no stale fields or response on the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pointer       <= '0;
            r_grant         <= '0;
            r_write         <= 1'b0;
            r_address       <= '0;
            r_write_data    <= '0;
            r_strobe        <= '0;
            r_rsp_status    <= RGGEN_OKAY;
            r_rsp_read_data <= '0;
        end else begin
            if (w_accept) begin
                r_pointer    <= w_next_pointer;
                r_grant      <= w_grant;
                r_write      <= w_sel_write;
                r_address    <= w_sel_address;
                r_write_data <= w_sel_write_data;
                r_strobe     <= w_sel_strobe;
            end
            // Acknowledge takes priority over a simultaneous timeout expiry.
            if (w_ack) begin
                r_rsp_status    <= i_status;
                r_rsp_read_data <= r_write ? '0 : i_read_data;
            end else if (w_expired) begin
                r_rsp_status    <= RGGEN_SLAVE_ERROR;
                r_rsp_read_data <= '0;
            end
        end
    end

    assign o_req_ready     = (r_state == RGGEN_ARBITER_IDLE)    ? w_grant : '0;
    assign o_rsp_valid     = (r_state == RGGEN_ARBITER_RESPOND) ? r_grant : '0;
    assign o_valid         = (r_state == RGGEN_ARBITER_BUSY);
    assign o_write         = r_write;
    assign o_address       = r_address;
    assign o_write_data    = r_write_data;
    assign o_strobe        = r_strobe;
    assign o_rsp_status    = r_rsp_status;
    assign o_rsp_read_data = r_rsp_read_data;

endmodule
